// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART telemetry frame definitions
//
// Purpose: frame state encoding, frame layout constants and the baud divider
//          shared by the frame scheduler and the byte serializer.
// Ports:   none (package).
package uart_pkg;

  // Telemetry frame progression; IDLE means no frame in flight.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DHI,
    ST_DLO,
    ST_TERM
  } frame_state_e;

  localparam int         FRAME_BYTES   = 4;
  localparam logic [7:0] TERM_BYTE_DEF = 8'h0A;
  localparam logic [7:0] HDR_BASE_DEF  = 8'h80;

  // Serializer bit period in clk cycles (27 MHz / 115200 baud).
  localparam int CLK_HZ       = 27_000_000;
  localparam int BAUD         = 115_200;
  localparam int DELAY_FRAMES = CLK_HZ / BAUD;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin request picker
//
// Purpose: picks the first requesting index at or after ptr, ascending with
//          wrap-around. No state; the pointer lives in the caller.
// Ports:
//   req       in  N      request vector
//   ptr       in  IDX_W  highest-priority index (must be < N)
//   grant     out N      one-hot grant (zero when no request)
//   grant_idx out IDX_W  index of the granted requester
//   any       out 1      at least one request present
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W:0] pos;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate index (ptr + i) mod N; one extra bit avoids overflow before the wrap.
      pos = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(N)) begin
        pos = pos - (IDX_W + 1)'(N);
      end
      if (!any && req[pos[IDX_W-1:0]]) begin
        any       = 1'b1;
        grant_idx = pos[IDX_W-1:0];
      end
    end
    grant[grant_idx] = any;
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - round-robin sample-to-UART frame sequencer
//
// Purpose: shares one byte-level UART transmitter between NUM_CH producers.
//          Grants one requester round-robin, latches its sample and emits the
//          4-byte frame {HDR_BASE|ch, sample[DATA_W-1:8], sample[7:0], TERM_BYTE}.
// Ports:
//   clk       in  1              system clock
//   rst_n     in  1              synchronous active-low reset
//   en        in  1              allows new grants; an in-flight frame always completes
//   req       in  NUM_CH         level requests
//   sample    in  NUM_CH*DATA_W  packed samples, channel ch at [ch*DATA_W +: DATA_W]
//   ack       out NUM_CH         one-cycle one-hot pulse when a sample is latched
//   tx_data   out 8              byte to the serializer
//   tx_valid  out 1              tx_data valid
//   tx_ready  in  1              serializer accepts the byte
//   busy      out 1              frame in flight
//   frame_cnt out 16             completed frames, wrapping
module uart_frame_scheduler
  import uart_pkg::*;
#(
  parameter int         NUM_CH    = 2,
  parameter int         DATA_W    = 15,
  parameter logic [7:0] TERM_BYTE = TERM_BYTE_DEF,
  parameter logic [7:0] HDR_BASE  = HDR_BASE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] sample,
  output logic [NUM_CH-1:0]        ack,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [15:0]              frame_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  frame_state_e       state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [DATA_W-1:0]  smp_q;
  logic [DATA_W-1:0]  smp_d;
  logic [NUM_CH-1:0]  ack_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;
  logic               busy_q;
  logic [15:0]        frame_cnt_q;
  logic [15:0]        frame_cnt_d;

  logic [NUM_CH-1:0]  grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;

  rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // One-hot AND-OR mux of the granted channel's sample.
  always_comb begin
    smp_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      smp_d = smp_d | ({DATA_W{grant[c]}} & sample[c*DATA_W +: DATA_W]);
    end
  end

  // Pointer moves to the channel just after the winner so it drops to lowest priority.
  always_comb begin
    if (grant_idx == IDX_W'(NUM_CH - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = grant_idx + IDX_W'(1);
    end
  end

  assign frame_cnt_d = frame_cnt_q + 16'd1;

  // Every output is registered; tx_data_q is loaded with the byte of the state being
  // entered, so it is held untouched while tx_ready is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      smp_q       <= '0;
      ack_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (en && grant_any) begin
            ack_q      <= grant;
            smp_q      <= smp_d;
            ptr_q      <= ptr_d;
            // The granted index lives on only in the header byte.
            tx_data_q  <= HDR_BASE | 8'(grant_idx);
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (tx_ready) begin
            tx_data_q <= 8'(smp_q[DATA_W-1:8]);
            state_q   <= ST_DHI;
          end
        end
        ST_DHI: begin
          if (tx_ready) begin
            tx_data_q <= smp_q[7:0];
            state_q   <= ST_DLO;
          end
        end
        ST_DLO: begin
          if (tx_ready) begin
            tx_data_q <= TERM_BYTE;
            state_q   <= ST_TERM;
          end
        end
        ST_TERM: begin
          if (tx_ready) begin
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - self-checking bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 15;

  logic        clk = 1'b0;
  logic        rst_n, en, tx_ready;
  logic [1:0]  req;
  logic [29:0] sample;
  logic [1:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_valid, busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  uart_frame_scheduler #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .TERM_BYTE (8'h0A),
    .HDR_BASE  (8'h80)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .sample    (sample),
    .ack       (ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a list of 4 bytes and a position in it.
  bit          m_busy = 0;
  int          m_pos  = 0;
  int          m_ptr  = 0;
  logic [15:0] m_cnt  = 0;
  logic [15:0] m_offset = 0;
  logic [1:0]  m_ack  = 0;
  logic [7:0]  m_bytes [4];
  int          cyc    = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_pos = 0; m_ptr = 0; m_cnt = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      if (m_busy) begin
        if (tx_ready) begin
          m_pos++;
          if (m_pos == 4) begin
            m_busy = 0;
            m_cnt++;
          end
        end
      end else if (en && req != 0) begin
        int g;
        logic [14:0] s;
        g = -1;
        for (int k = 0; k < NUM_CH; k++)
          if (g < 0 && req[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
        s = sample[g*DATA_W +: DATA_W];
        m_bytes[0] = 8'h80 | 8'(g);
        m_bytes[1] = 8'(s >> 8);
        m_bytes[2] = s[7:0];
        m_bytes[3] = 8'h0A;
        m_ack  = 2'(1 << g);
        m_pos  = 0;
        m_busy = 1;
        m_ptr  = (g + 1) % NUM_CH;
      end
    end
  end

  // Compare process plus transfer log, sampled mid-cycle.
  bit         cmp_on = 0;
  logic [7:0] log_q [$];
  int         stamp_q [$];
  int         n_acks = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("tx_valid", 32'(tx_valid), 32'(m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("frame_cnt", 32'(frame_cnt), 32'(16'(m_cnt + m_offset)));
      if (m_busy) chk("tx_data", 32'(tx_data), 32'(m_bytes[m_pos]));
      if (tx_valid && tx_ready) begin
        log_q.push_back(tx_data);
        stamp_q.push_back(cyc);
      end
      if (ack != 0) n_acks++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 300) begin
      tick();
      t++;
    end
    chk({name, "_idle_timeout"}, 32'(busy), 32'(0));
  endtask

  task automatic expect_bytes(input string name, input logic [7:0] e [$]);
    chk({name, "_len"}, 32'(log_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (i < log_q.size()) chk(name, 32'(log_q[i]), 32'(e[i]));
  endtask

  task automatic clear_log();
    log_q.delete();
    stamp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e [$];
    logic [1:0] order [3];
    logic [1:0] rq;
    int na, t, acks0;

    rst_n = 0; en = 1; tx_ready = 1; req = 0; sample = 0;
    tick(); tick();
    rst_n = 1;
    cmp_on = 1;

    // Reset state
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);

    // Single frame
    clear_log();
    acks0 = n_acks;
    sample[14:0] = 15'h1234;
    req = 2'b01;
    tick();
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_hdr", 32'(tx_data), 32'h80);
    req = 2'b00;
    wait_idle("single");
    e = '{8'h80, 8'h12, 8'h34, 8'h0A};
    expect_bytes("single_bytes", e);
    if (stamp_q.size() == 4) chk("single_consecutive", 32'(stamp_q[3] - stamp_q[0]), 3);
    chk("single_frame_cnt", 32'(frame_cnt), 1);
    chk("single_busy", 32'(busy), 0);
    tick(); tick();
    chk("single_ack_count", 32'(n_acks - acks0), 1);

    // Round-robin with both channels held
    rst_n = 0; tick(); rst_n = 1;
    clear_log();
    sample[14:0]  = 15'h7FFF;
    sample[29:15] = 15'h0001;
    req = 2'b11;
    na = 0; t = 0;
    while (na < 3 && t < 60) begin
      tick();
      t++;
      if (ack != 0) begin
        order[na] = ack;
        na++;
      end
    end
    req = 2'b00;
    chk("rr_grants_seen", 32'(na), 3);
    if (na == 3) begin
      chk("rr_grant0", 32'(order[0]), 32'h1);
      chk("rr_grant1", 32'(order[1]), 32'h2);
      chk("rr_grant2", 32'(order[2]), 32'h1);
    end
    wait_idle("rr");
    e = '{8'h80, 8'h7F, 8'hFF, 8'h0A, 8'h81, 8'h00, 8'h01, 8'h0A, 8'h80, 8'h7F, 8'hFF, 8'h0A};
    expect_bytes("rr_bytes", e);
    if (stamp_q.size() == 12) begin
      chk("rr_gap1", 32'(stamp_q[4] - stamp_q[3]), 2);
      chk("rr_gap2", 32'(stamp_q[8] - stamp_q[7]), 2);
    end

    // Backpressure during DHI
    clear_log();
    sample[14:0] = 15'h1234;
    req = 2'b01;
    tick();
    chk("bp_ack", 32'(ack), 32'h1);
    req = 2'b00;
    tick();
    tx_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 32'(tx_valid), 1);
      chk("bp_hold_data", 32'(tx_data), 32'h12);
    end
    tx_ready = 1;
    tick();
    chk("bp_resume", 32'(tx_data), 32'h34);
    wait_idle("bp");
    e = '{8'h80, 8'h12, 8'h34, 8'h0A};
    expect_bytes("bp_bytes", e);

    // en gating with ch1 pending
    clear_log();
    sample[14:0]  = 15'h2BCD;
    sample[29:15] = 15'h0155;
    req = 2'b01;
    tick();
    chk("en_ack0", 32'(ack), 32'h1);
    req = 2'b00;
    tick(); tick();
    en = 0;
    req = 2'b10;
    wait_idle("en_frame");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("en_no_ack", 32'(ack), 0);
    end
    en = 1;
    tick();
    chk("en_ack1", 32'(ack), 32'h2);
    chk("en_hdr1", 32'(tx_data), 32'h81);
    req = 2'b00;
    wait_idle("en_second");
    e = '{8'h80, 8'h2B, 8'hCD, 8'h0A, 8'h81, 8'h01, 8'h55, 8'h0A};
    expect_bytes("en_bytes", e);

    // Reset mid-frame while in DHI
    sample[14:0] = 15'h1234;
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mrst_tx_valid", 32'(tx_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_frame_cnt", 32'(frame_cnt), 0);
    req = 2'b11;
    tick();
    chk("mrst_ack_ch0", 32'(ack), 32'h1);
    req = 2'b00;
    wait_idle("mrst");

    // Randomized traffic following the requester protocol
    rq = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        if (rq[c] && ack[c]) rq[c] = 0;
        else if (!rq[c] && ($urandom % 4 == 0)) begin
          sample[c*DATA_W +: DATA_W] = 15'($urandom);
          rq[c] = 1;
        end
      end
      req = rq;
      en = ($urandom % 8) != 0;
      tx_ready = ($urandom % 4) != 0;
    end
    req = 0; en = 1; tx_ready = 1;
    tick();
    wait_idle("rand");

    // frame_cnt wrap from 16'hFFFF
    force dut.frame_cnt_q = 16'hFFFF;
    m_offset = 16'hFFFF - m_cnt;
    #1;
    release dut.frame_cnt_q;
    #1;
    chk("wrap_preload", 32'(frame_cnt), 32'hFFFF);
    sample[14:0] = 15'h0042;
    req = 2'b01;
    tick();
    req = 2'b00;
    wait_idle("wrap");
    chk("wrap_frame_cnt", 32'(frame_cnt), 0);

    tick(); tick();
    cmp_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
